// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencing controller for a WIDTH-bit shift/count datapath.
// Latches a job (seed, length), loads the seed into the datapath for one cycle,
// enables the datapath for exactly 'length' cycles, then captures the datapath
// output and pulses done_o for one cycle.
// Optional feature macro: SHIFT_SEQ_CTRL_HOLD_EN adds hold_i, which pauses RUN
// (no shift enable, remaining count frozen) while it is high.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             abort_i,
`ifdef SHIFT_SEQ_CTRL_HOLD_EN
   input  logic             hold_i,
`endif
   input  logic [CNT_W-1:0] len_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [WIDTH-1:0] q_i,
   output logic             load_o,
   output logic [WIDTH-1:0] seed_o,
   output logic             shift_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [CNT_W-1:0] remain_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_CAPT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic             hold_w;

`ifdef SHIFT_SEQ_CTRL_HOLD_EN
   assign hold_w = hold_i;
`else
   assign hold_w = 1'b0;
`endif

   // State and job registers; everything clears on reset, so the job is lost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         remain_q <= CNT_ZERO;
         seed_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         seed_q   <= seed_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   // Next-state and next-value logic; abort beats every other request
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      seed_d   = seed_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // start_i is only looked at here, so requests while busy are dropped
            if (start_i && !abort_i) begin
               remain_d = len_i;
               seed_d   = seed_i;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               remain_d = CNT_ZERO;
               state_d  = ST_IDLE;
            end else if (remain_q != CNT_ZERO) begin
               state_d = ST_RUN;
            end else begin
               // zero-length job: skip straight to capture
               state_d = ST_CAPT;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               remain_d = CNT_ZERO;
               state_d  = ST_IDLE;
            end else if (!hold_w) begin
               // RUN is only entered with remain_q >= 1, so this never wraps
               remain_d = remain_q - CNT_ONE;
               if (remain_q == CNT_ONE) begin
                  state_d = ST_CAPT;
               end
            end
         end
         ST_CAPT: begin
            if (abort_i) begin
               remain_d = CNT_ZERO;
               state_d  = ST_IDLE;
            end else begin
               // datapath has settled after the last shift edge; grab it now
               result_d = q_i;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath strobes decode directly from the state register
   always_comb begin
      load_o     = 1'b0;
      shift_en_o = 1'b0;
      busy_o     = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            load_o = 1'b1;
            busy_o = 1'b1;
         end
         ST_RUN: begin
            shift_en_o = !hold_w;
            busy_o     = 1'b1;
         end
         ST_CAPT: begin
            busy_o = 1'b1;
         end
         default: begin
            load_o     = 1'b0;
            shift_en_o = 1'b0;
            busy_o     = 1'b0;
         end
      endcase
   end

   assign seed_o   = seed_q;
   assign result_o = result_q;
   assign remain_o = remain_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl with a behavioural 4-bit up-counter datapath.
// Covers reset, table-driven jobs, busy/start interaction, abort, mid-job
// reset, randomized jobs with input noise, and (with SHIFT_SEQ_CTRL_HOLD_EN)
// the hold feature.
module tb_shift_seq_ctrl;

   localparam int W = 4;
   localparam int C = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start_i;
   logic         abort_i;
`ifdef SHIFT_SEQ_CTRL_HOLD_EN
   logic         hold_i;
`endif
   logic [C-1:0] len_i;
   logic [W-1:0] seed_i;
   logic [W-1:0] q_model = '0;
   logic         load_o;
   logic [W-1:0] seed_o;
   logic         shift_en_o;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] result_o;
   logic [C-1:0] remain_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
      .clk        (clk),
      .reset      (reset_n),
      .start_i    (start_i),
      .abort_i    (abort_i),
`ifdef SHIFT_SEQ_CTRL_HOLD_EN
      .hold_i     (hold_i),
`endif
      .len_i      (len_i),
      .seed_i     (seed_i),
      .q_i        (q_model),
      .load_o     (load_o),
      .seed_o     (seed_o),
      .shift_en_o (shift_en_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .remain_o   (remain_o)
   );

   // Behavioural datapath: parallel load has priority over count-up
   always @(posedge clk) begin
      if (load_o)          q_model <= seed_o;
      else if (shift_en_o) q_model <= q_model + 4'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " load_o"},     int'(load_o), 0);
      check({tag, " shift_en_o"}, int'(shift_en_o), 0);
      check({tag, " busy_o"},     int'(busy_o), 0);
      check({tag, " done_o"},     int'(done_o), 0);
      check({tag, " result_o"},   int'(result_o), 0);
      check({tag, " remain_o"},   int'(remain_o), 0);
      check({tag, " seed_o"},     int'(seed_o), 0);
   endtask

   // Reference model: a job of length l on an up-counter seeded with s ends
   // at s+l (mod 16), and done appears l+2 edges after the start edge.
   function automatic int model_result(input int s, input int l);
      return (s + l) % 16;
   endfunction

   // Runs one job from an IDLE negedge; returns at the negedge of the done cycle.
   // k counts edges after the start edge E0, observed at the following negedge.
   task automatic run_job(input string tag, input int s, input int l,
                          input int exp_res, input int exp_done_k, input bit noise);
      int loads = 0, shifts = 0, dones = 0, done_k = -1, res = -1;
      int rem_bad = 0, busy_bad = 0, seen_seed = -1;
      int exp_rem;
      logic [31:0] lv;
      lv      = l;
      start_i = 1'b1;
      seed_i  = s[W-1:0];
      len_i   = lv[C-1:0];
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 0; k <= l + 2; k++) begin
         if (k > 0) @(negedge clk);
         if (load_o) begin loads++; seen_seed = int'(seed_o); end
         if (shift_en_o) shifts++;
         if (done_o) begin
            dones++;
            if (done_k < 0) done_k = k;
            res = int'(result_o);
         end
         if (k == 0)      exp_rem = l;
         else if (k <= l) exp_rem = l - k + 1;
         else             exp_rem = 0;
         if (int'(remain_o) != exp_rem) rem_bad++;
         if (int'(busy_o) != ((k <= l + 1) ? 1 : 0)) busy_bad++;
         // noise on the request inputs can only matter once the FSM is idle
         if (noise && k <= l + 1) begin
            start_i = 1'($urandom_range(0, 1));
            seed_i  = W'($urandom);
            len_i   = C'($urandom);
         end else begin
            start_i = 1'b0;
         end
      end
      check({tag, " load count"},   loads, 1);
      check({tag, " seed_o"},       seen_seed, s);
      check({tag, " shift count"},  shifts, l);
      check({tag, " done count"},   dones, 1);
      check({tag, " done latency"}, done_k, exp_done_k);
      check({tag, " result_o"},     res, exp_res);
      check({tag, " remain bad"},   rem_bad, 0);
      check({tag, " busy bad"},     busy_bad, 0);
      $display("job %s seed=%0d len=%0d result=%0d done_at=E0+%0d", tag, s, l, res, done_k);
   endtask

   typedef struct {
      int seed;
      int len;
      int exp_result;
      int exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int prev_res, cnt, seen, ld_k2, loads;

      vecs[0] = '{9,   3, 12,   5};
      vecs[1] = '{7,   0,  7,   2};
      vecs[2] = '{15,  1,  0,   3};
      vecs[3] = '{5,  16,  5,  18};
      vecs[4] = '{10,  2, 12,   4};
      vecs[5] = '{0, 255, 15, 257};

      // Case 1: reset, then idle with a request pattern but no start
      reset_n = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
`ifdef SHIFT_SEQ_CTRL_HOLD_EN
      hold_i  = 1'b0;
`endif
      seed_i  = 4'hF;
      len_i   = 8'd5;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cnt += int'(busy_o) + int'(load_o) + int'(shift_en_o) + int'(done_o);
      end
      check("idle activity", cnt, 0);
      check_all_zero("idle");

      // Table-driven jobs
      foreach (vecs[i]) begin
         run_job($sformatf("vec%0d", i), vecs[i].seed, vecs[i].len,
                 vecs[i].exp_result, vecs[i].exp_done, 1'b0);
      end

      // abort wins over start in IDLE
      start_i = 1'b1; abort_i = 1'b1; seed_i = 4'h3; len_i = 8'd4;
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0;
      check("abort-vs-start busy_o", int'(busy_o), 0);
      check("abort-vs-start load_o", int'(load_o), 0);
      $display("txn abort+start in idle busy=%0d", busy_o);

      // Case 4: start held high through a len=2 job
      start_i = 1'b1; seed_i = 4'h1; len_i = 8'd2;
      loads = 0; ld_k2 = -1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (load_o) begin
            loads++;
            if (k > 0) ld_k2 = k;
         end
      end
      start_i = 1'b0;
      check("held-start loads", loads, 2);
      check("held-start second load k", ld_k2, 5);
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
         @(negedge clk);
         if (done_o) seen = 1;
      end
      check("held-start second done", seen, 1);
      check("held-start result", int'(result_o), 3);
      $display("txn held start loads=%0d second_load_k=%0d result=%0d", loads, ld_k2, result_o);

      // Case 5a: abort after two of six shift cycles
      prev_res = int'(result_o);
      start_i = 1'b1; seed_i = 4'h3; len_i = 8'd6;
      @(negedge clk);            // k=0 LOAD
      start_i = 1'b0;
      @(negedge clk);            // k=1 first shift
      @(negedge clk);            // k=2 second shift
      check("abort pre shift_en", int'(shift_en_o), 1);
      abort_i = 1'b1;
      @(negedge clk);            // k=3 back in IDLE
      abort_i = 1'b0;
      check("abort shift_en_o", int'(shift_en_o), 0);
      check("abort busy_o", int'(busy_o), 0);
      check("abort load_o", int'(load_o), 0);
      check("abort remain_o", int'(remain_o), 0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cnt += int'(done_o);
      end
      check("abort done count", cnt, 0);
      check("abort result kept", int'(result_o), prev_res);
      $display("txn abort mid-run result=%0d", result_o);

      // Case 5b: asynchronous reset mid-RUN
      start_i = 1'b1; seed_i = 4'h6; len_i = 8'd6;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midreset pre busy", int'(busy_o), 1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post-reset busy", int'(busy_o), 0);
      $display("txn reset mid-run");

`ifdef SHIFT_SEQ_CTRL_HOLD_EN
      // Case 6: hold for two cycles mid-RUN
      begin
         int shifts = 0, done_k = -1;
         start_i = 1'b1; seed_i = 4'h2; len_i = 8'd4;
         @(negedge clk);
         start_i = 1'b0;
         for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            hold_i = (k == 2 || k == 3);
            #1;
            if (shift_en_o) shifts++;
            if (done_o && done_k < 0) done_k = k;
         end
         hold_i = 1'b0;
         check("hold shift count", shifts, 4);
         check("hold done latency", done_k, 8);
         check("hold result", int'(result_o), 6);
         $display("txn hold shifts=%0d done_at=E0+%0d result=%0d", shifts, done_k, result_o);
         @(negedge clk);
      end
`endif

      // Randomized jobs against the reference model, with noisy inputs
      for (int j = 0; j < 40; j++) begin
         int s, l, gap;
         s   = $urandom_range(0, 15);
         l   = $urandom_range(0, 20);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) @(negedge clk);
         run_job($sformatf("rnd%0d", j), s, l, model_result(s, l), l + 2, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencing controller for the 4-bit shift/count datapath that drives q_o.
- Accepts a job (seed, shift length), loads the seed into the datapath, then enables it for exactly N cycles.
- Captures the final datapath value and reports completion with a one-cycle pulse.
- Sits between a requester (CPU or test sequencer) and the datapath's load/enable inputs.

Parameters:
- WIDTH, 4: datapath width; width of seed_i, seed_o, q_i, result_o.
- CNT_W, 8: shift-length counter width; max job length is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  job request; sampled only in IDLE.
- abort_i  in  1  synchronous abort of the current job.
- len_i  in  CNT_W  number of shift cycles; sampled with start_i.
- seed_i  in  WIDTH  initial datapath value; sampled with start_i.
- q_i  in  WIDTH  current datapath output (feedback).
- load_o  out  1  datapath parallel-load strobe.
- seed_o  out  WIDTH  value to load; valid while load_o=1.
- shift_en_o  out  1  datapath shift/count enable.
- busy_o  out  1  high in LOAD, RUN and CAPT.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  q_i captured at job end; held until the next completed job.
- remain_o  out  CNT_W  shifts still to issue.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0, including result_o, remain_o and seed_o. Release is synchronous to the next clk edge.
- All outputs are registered, except load_o, shift_en_o and busy_o, which decode the state register.
- FSM states: IDLE, LOAD, RUN, CAPT.
- IDLE:
  - start_i=1 and abort_i=0: latch len_i and seed_i; remain_o<=len_i; next state LOAD.
  - abort_i wins over start_i in the same cycle; start_i is then ignored.
- LOAD:
  - Exactly 1 cycle; load_o=1, seed_o=latched seed.
  - Next state RUN if len>0, else CAPT.
- RUN:
  - shift_en_o=1 every cycle.
  - remain_o decrements at each edge.
  - Edge with remain_o==1 -> CAPT, with remain_o reaching 0.
  - shift_en_o is high for exactly len cycles.
- CAPT:
  - 1 cycle; shift_en_o=0.
  - result_o<=q_i and done_o<=1 at the edge leaving CAPT; next state IDLE.
  - done_o is therefore high during the first IDLE cycle, with result_o already valid.
- Latency:
  - Start sampled at edge E0: load_o high E0-E1; shift_en_o high E1 to E1+len; CAPT E1+len to E2+len.
  - done_o high from edge E0+len+2 for 1 cycle.
- start_i while busy_o=1: ignored, not queued.
- start_i in the cycle done_o=1: accepted, since the FSM is already in IDLE.
- abort_i=1 in LOAD, RUN or CAPT: next edge -> IDLE. No done_o; result_o unchanged; remain_o<=0; shift_en_o and load_o low from that edge.
- len_i=2^CNT_W-1: supported; no wrap of remain_o.
- len_i=0: LOAD followed directly by CAPT, with zero shift cycles.
- reset asserted mid-job: immediate return to IDLE with all outputs 0; the job is lost.

Optional Feature:
- Macro: SHIFT_SEQ_CTRL_HOLD_EN.
- Defined:
  - Adds input port hold_i (1 bit).
  - In RUN, hold_i=1 forces shift_en_o=0 and freezes remain_o; the state stays RUN.
  - abort_i still takes effect during hold.
  - done_o is delayed by the number of held cycles.
  - hold_i is ignored in IDLE, LOAD and CAPT.
- Undefined: hold_i port does not exist; RUN shifts every cycle.

Test Plan:
- Bench setup for all cases: behavioural 4-bit up-counter with load/enable, driven by load_o/seed_o/shift_en_o, feeding q_o back to q_i.
- Case 1: reset=0 for 2 cycles, then release; seed_i=4'hF, len_i=5 held with start_i=0 -> all outputs 0, busy_o=0, no activity.
- Case 2: start_i pulse with seed_i=4'b1001, len_i=3 -> load_o exactly 1 cycle with seed_o=1001; shift_en_o exactly 3 cycles; done_o rises at E0+5; result_o=4'b1100; remain_o sequence 3,3,2,1,0.
- Case 3: len_i=0, seed_i=4'h7 -> zero shift_en_o cycles; done_o at E0+2; result_o=4'h7.
- Case 4: start_i held high through a len=2 job (busy_o=1) -> second job starts only in the done_o cycle; exactly one load_o per accepted job.
- Case 5: abort_i pulse after 2 of 6 shift cycles -> shift_en_o low next cycle; no done_o; result_o keeps the previous value; reset=0 mid-RUN clears all outputs asynchronously.
- Case 6 (SHIFT_SEQ_CTRL_HOLD_EN defined): len_i=4, hold_i high for 2 cycles mid-RUN -> shift_en_o total 4 cycles; done_o at E0+8; result_o=seed+4.
